// File: rtl/debug_clk_en_gen.sv
// debug_clk_en_gen: debounced RUN/STEP/SLOW/HALT clock-enable source for the Hack CPU
module debug_clk_en_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = 20,
  parameter int SLOW_DIV        = 25000000,
  parameter int DIV_W           = 25
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_STEP_BTN,
  input  logic [1:0]  i_MODE_SW,
  output logic        o_Debug_CLK_EN,
  output logic [1:0]  o_MODE,
  output logic [15:0] o_STEP_CNT
);
  typedef enum logic [1:0] {RUN, STEP, SLOW, HALT} mode_e;
  mode_e mode, nxt;
  logic [2:0] s1, s2, d;
  logic [DEB_W-1:0] c [3];
  logic d_prev, step_req, mode_chg, div_end;
  logic [DIV_W-1:0] div;
  assign nxt      = mode_e'(d[2:1]);
  assign mode_chg = nxt != mode;
  assign div_end  = div == DIV_W'(SLOW_DIV - 1);
  assign o_MODE   = mode;
  // enable is computed from the mode being applied at this edge so EN and o_MODE always agree
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      s1 <= '0;
      s2 <= '0;
      d <= '0;
      for (int i = 0; i < 3; i++) c[i] <= '0;
      d_prev <= 1'b0;
      step_req <= 1'b0;
      mode <= RUN;
      div <= '0;
      o_Debug_CLK_EN <= 1'b0;
      o_STEP_CNT <= '0;
    end else begin
      s1 <= {i_MODE_SW, i_STEP_BTN};
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == d[i]) c[i] <= '0;
        else if (c[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          d[i] <= s2[i];
          c[i] <= '0;
        end else c[i] <= c[i] + 1'b1;
      end
      d_prev <= d[0];
      step_req <= d[0] & ~d_prev;
      mode <= nxt;
      div <= (nxt != SLOW || mode_chg || div_end) ? '0 : div + 1'b1;
      o_Debug_CLK_EN <= nxt == RUN  ? 1'b1 :
                        nxt == STEP ? step_req & ~mode_chg :
                        nxt == SLOW ? div_end & ~mode_chg : 1'b0;
      if (mode == RUN) o_STEP_CNT <= '0;
      else if (o_Debug_CLK_EN && (mode == STEP || mode == SLOW)) o_STEP_CNT <= o_STEP_CNT + 1'b1;
    end
  end
endmodule
